// File: rtl/axil_ram_ext.sv
// axil_ram_ext -- AXI4-Lite slave RAM with byte strobes, decoupled AW/W
// acceptance, configurable read latency and DECERR for unimplemented words.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   s_axil_aw*               write address channel (awprot ignored)
//   s_axil_w*                write data channel, wstrb = byte enables
//   s_axil_b*                write response (OKAY / DECERR)
//   s_axil_ar*               read address channel (arprot ignored)
//   s_axil_r*                read data channel (OKAY / DECERR, rdata=0 on DECERR)
module axil_ram_ext #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 16,
  parameter int STRB_WIDTH   = DATA_WIDTH/8,
  parameter int MEM_WORDS    = 1024,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
  input  logic [2:0]            s_axil_awprot,
  input  logic                  s_axil_awvalid,
  output logic                  s_axil_awready,
  input  logic [DATA_WIDTH-1:0] s_axil_wdata,
  input  logic [STRB_WIDTH-1:0] s_axil_wstrb,
  input  logic                  s_axil_wvalid,
  output logic                  s_axil_wready,
  output logic [1:0]            s_axil_bresp,
  output logic                  s_axil_bvalid,
  input  logic                  s_axil_bready,
  input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
  input  logic [2:0]            s_axil_arprot,
  input  logic                  s_axil_arvalid,
  output logic                  s_axil_arready,
  output logic [DATA_WIDTH-1:0] s_axil_rdata,
  output logic [1:0]            s_axil_rresp,
  output logic                  s_axil_rvalid,
  input  logic                  s_axil_rready
);

  localparam int ADDR_LSB = $clog2(STRB_WIDTH);
  localparam int IDX_W    = ADDR_WIDTH - ADDR_LSB;
  localparam int MEM_AW   = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [IDX_W:0] MEM_WORDS_W = (IDX_W+1)'(MEM_WORDS);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam logic [1:0] LAT_M1      = 2'(READ_LATENCY - 1);

  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

  logic                  aw_held, w_held;
  logic [IDX_W-1:0]      aw_idx;
  logic [DATA_WIDTH-1:0] w_data;
  logic [STRB_WIDTH-1:0] w_strb;
  logic                  bvalid_q;
  logic [1:0]            bresp_q;
  logic                  rd_busy, rvalid_q;
  logic [1:0]            rd_cnt;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [1:0]            rresp_q;

  logic             aw_hs, w_hs, ar_hs, commit, aw_ok, ar_ok;
  logic [IDX_W-1:0] ar_idx;

  // prot fields and sub-word address bits carry no meaning here
  logic unused_bits;
  assign unused_bits = ^{s_axil_awprot, s_axil_arprot, s_axil_awaddr, s_axil_araddr};

  function automatic logic idx_ok(input logic [IDX_W-1:0] idx);
    return {1'b0, idx} < MEM_WORDS_W;
  endfunction

  assign ar_idx = s_axil_araddr[ADDR_WIDTH-1:ADDR_LSB];
  assign aw_ok  = idx_ok(aw_idx);
  assign ar_ok  = idx_ok(ar_idx);

  // A commit frees both holding slots in the same cycle, so a new AW/W pair
  // can be taken while the previous one retires: one write per cycle when
  // bready is held high. With B stalled and a pair held, awready/wready drop.
  assign commit         = aw_held && w_held && (!bvalid_q || s_axil_bready);
  assign s_axil_awready = !rst && (!aw_held || commit);
  assign s_axil_wready  = !rst && (!w_held || commit);
  assign s_axil_arready = !rst && !rd_busy;

  assign aw_hs = s_axil_awvalid && s_axil_awready;
  assign w_hs  = s_axil_wvalid && s_axil_wready;
  assign ar_hs = s_axil_arvalid && s_axil_arready;

  assign s_axil_bvalid = bvalid_q;
  assign s_axil_bresp  = bresp_q;
  assign s_axil_rvalid = rvalid_q;
  assign s_axil_rdata  = rdata_q;
  assign s_axil_rresp  = rresp_q;

  // write channel state
  always_ff @(posedge clk) begin
    if (rst) begin
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      aw_idx   <= '0;
      w_data   <= '0;
      w_strb   <= '0;
      bvalid_q <= 1'b0;
      bresp_q  <= RESP_OKAY;
    end else begin
      if (commit) begin
        aw_held  <= 1'b0;
        w_held   <= 1'b0;
        bvalid_q <= 1'b1;
        bresp_q  <= aw_ok ? RESP_OKAY : RESP_DECERR;
      end else if (s_axil_bready) begin
        bvalid_q <= 1'b0;
      end
      // a new capture wins over the clear from a same-cycle commit
      if (aw_hs) begin
        aw_held <= 1'b1;
        aw_idx  <= s_axil_awaddr[ADDR_WIDTH-1:ADDR_LSB];
      end
      if (w_hs) begin
        w_held <= 1'b1;
        w_data <= s_axil_wdata;
        w_strb <= s_axil_wstrb;
      end
    end
  end

  // storage: not reset; byte lanes written under strobe
  always_ff @(posedge clk) begin
    if (!rst && commit && aw_ok) begin
      for (int i = 0; i < STRB_WIDTH; i++) begin
        if (w_strb[i]) mem[aw_idx[MEM_AW-1:0]][8*i +: 8] <= w_data[8*i +: 8];
      end
    end
  end

  // read path: data sampled at the AR handshake (so a same-cycle commit is
  // not seen), then rvalid raised READ_LATENCY-1 edges later.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_busy  <= 1'b0;
      rvalid_q <= 1'b0;
      rd_cnt   <= '0;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
    end else if (ar_hs) begin
      rd_busy  <= 1'b1;
      rd_cnt   <= LAT_M1;
      rvalid_q <= (LAT_M1 == 2'd0);
      rdata_q  <= ar_ok ? mem[ar_idx[MEM_AW-1:0]] : '0;
      rresp_q  <= ar_ok ? RESP_OKAY : RESP_DECERR;
    end else if (rvalid_q && s_axil_rready) begin
      rvalid_q <= 1'b0;
      rd_busy  <= 1'b0;
    end else if (rd_busy && !rvalid_q) begin
      rd_cnt <= rd_cnt - 2'd1;
      if (rd_cnt == 2'd1) rvalid_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_axil_ram_ext.sv
module tb_axil_ram_ext;

  typedef struct packed {
    logic [31:0] d;
    logic [1:0]  r;
  } rexp_t;

  logic        clk, rst;
  logic [15:0] awaddr, araddr;
  logic        awvalid, wvalid, bready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  // latency-1 instance
  logic        awready1, wready1, bvalid1, arvalid1, arready1, rvalid1, rready1;
  logic [1:0]  bresp1, rresp1;
  logic [31:0] rdata1;
  // latency-4 instance (shares write-side inputs and araddr)
  logic        awready4, wready4, bvalid4, arvalid4, arready4, rvalid4, rready4;
  logic [1:0]  bresp4, rresp4;
  logic [31:0] rdata4;

  int n_tests = 0;
  int n_fail  = 0;

  logic [1:0]  bq[$];
  rexp_t       rq1[$], rq4[$];
  logic [31:0] model [1024];

  axil_ram_ext #(.READ_LATENCY(1)) dut (
    .clk(clk), .rst(rst),
    .s_axil_awaddr(awaddr), .s_axil_awprot(3'd0), .s_axil_awvalid(awvalid), .s_axil_awready(awready1),
    .s_axil_wdata(wdata), .s_axil_wstrb(wstrb), .s_axil_wvalid(wvalid), .s_axil_wready(wready1),
    .s_axil_bresp(bresp1), .s_axil_bvalid(bvalid1), .s_axil_bready(bready),
    .s_axil_araddr(araddr), .s_axil_arprot(3'd0), .s_axil_arvalid(arvalid1), .s_axil_arready(arready1),
    .s_axil_rdata(rdata1), .s_axil_rresp(rresp1), .s_axil_rvalid(rvalid1), .s_axil_rready(rready1)
  );

  axil_ram_ext #(.READ_LATENCY(4)) dut4 (
    .clk(clk), .rst(rst),
    .s_axil_awaddr(awaddr), .s_axil_awprot(3'd0), .s_axil_awvalid(awvalid), .s_axil_awready(awready4),
    .s_axil_wdata(wdata), .s_axil_wstrb(wstrb), .s_axil_wvalid(wvalid), .s_axil_wready(wready4),
    .s_axil_bresp(bresp4), .s_axil_bvalid(bvalid4), .s_axil_bready(bready),
    .s_axil_araddr(araddr), .s_axil_arprot(3'd0), .s_axil_arvalid(arvalid4), .s_axil_arready(arready4),
    .s_axil_rdata(rdata4), .s_axil_rresp(rresp4), .s_axil_rvalid(rvalid4), .s_axil_rready(rready4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_tests=%0d", n_tests);
    $fatal(1);
  end

  // scoreboard: responses are popped and compared when the handshake is
  // about to happen (inputs only change just after posedge)
  logic [1:0] eb;
  rexp_t      er;
  always @(negedge clk) begin
    if (!rst) begin
      if (bvalid1 && bready) begin
        n_tests++;
        if (bq.size() == 0) begin
          n_fail++;
          $display("FAIL b_unexpected: bvalid with nothing expected, bresp=%0d", bresp1);
        end else begin
          eb = bq.pop_front();
          if (bresp1 !== eb || bresp4 !== eb || bvalid4 !== 1'b1) begin
            n_fail++;
            $display("FAIL b_resp: got %0d/%0d (bvalid4=%0b) expected %0d", bresp1, bresp4, bvalid4, eb);
          end
        end
      end
      if (rvalid1 && rready1) begin
        n_tests++;
        if (rq1.size() == 0) begin
          n_fail++;
          $display("FAIL r1_unexpected: rvalid with nothing expected, rdata=%h", rdata1);
        end else begin
          er = rq1.pop_front();
          if (rdata1 !== er.d || rresp1 !== er.r) begin
            n_fail++;
            $display("FAIL r1_data: got %h/%0d expected %h/%0d", rdata1, rresp1, er.d, er.r);
          end
        end
      end
      if (rvalid4 && rready4) begin
        n_tests++;
        if (rq4.size() == 0) begin
          n_fail++;
          $display("FAIL r4_unexpected: rvalid with nothing expected, rdata=%h", rdata4);
        end else begin
          er = rq4.pop_front();
          if (rdata4 !== er.d || rresp4 !== er.r) begin
            n_fail++;
            $display("FAIL r4_data: got %h/%0d expected %h/%0d", rdata4, rresp4, er.d, er.r);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_wr(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s);
    int idx;
    idx = int'(a >> 2);
    if (idx < 1024)
      for (int i = 0; i < 4; i++) if (s[i]) model[idx][8*i +: 8] = d[8*i +: 8];
  endtask

  task automatic drive_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s,
                             input logic [1:0] exp);
    bit aw_ok, w_ok;
    int k;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    bq.push_back(exp);
    model_wr(a, d, s);
    aw_ok = 0; w_ok = 0; k = 0;
    while (!(aw_ok && w_ok) && k < 20) begin
      #1;
      if (awvalid && awready1) aw_ok = 1;
      if (wvalid && wready1) w_ok = 1;
      tick();
      if (aw_ok) awvalid = 1'b0;
      if (w_ok) wvalid = 1'b0;
      k++;
    end
    awvalid = 1'b0; wvalid = 1'b0;
    if (!(aw_ok && w_ok)) begin
      n_tests++; n_fail++;
      $display("FAIL write_timeout: addr %h aw_ok=%0b w_ok=%0b expected both accepted", a, aw_ok, w_ok);
    end
  endtask

  task automatic drive_read1(input logic [15:0] a, input logic [31:0] d, input logic [1:0] r);
    bit ok;
    int k;
    araddr = a; arvalid1 = 1'b1;
    rq1.push_back('{d: d, r: r});
    ok = 0; k = 0;
    while (!ok && k < 20) begin
      #1;
      if (arready1) ok = 1;
      tick();
      k++;
    end
    arvalid1 = 1'b0;
    if (!ok) begin
      n_tests++; n_fail++;
      $display("FAIL read_timeout: addr %h arready never 1, expected accepted", a);
    end
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((bq.size() != 0 || rq1.size() != 0 || rq4.size() != 0) && k < 40) begin
      tick();
      k++;
    end
    if (bq.size() != 0 || rq1.size() != 0 || rq4.size() != 0) begin
      n_tests++; n_fail++;
      $display("FAIL drain_timeout: pending b=%0d r1=%0d r4=%0d expected 0", bq.size(), rq1.size(), rq4.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    n_tests++;
    if ({awready1, wready1, bvalid1, arready1, rvalid1, bresp1, rresp1, rdata1,
         awready4, wready4, bvalid4, arready4, rvalid4, bresp4, rresp4, rdata4} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: awr=%0b wr=%0b bv=%0b arr=%0b rv=%0b rdata=%h, expected all 0",
               awready1, wready1, bvalid1, arready1, rvalid1, rdata1);
    end
    rst = 1'b0;
    #1;
    n_tests++;
    if ({awready1, wready1, arready1, arready4} !== 4'hF) begin
      n_fail++;
      $display("FAIL reset_release_ready: got %b expected 1111", {awready1, wready1, arready1, arready4});
    end
    tick();
  endtask

  task automatic test_basic();
    bready = 1'b1; rready1 = 1'b1;
    awaddr = 16'h0010; wdata = 32'hDEADBEEF; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    bq.push_back(2'b00);
    model_wr(16'h0010, 32'hDEADBEEF, 4'hF);
    #1;
    n_tests++;
    if ({awready1, wready1} !== 2'b11) begin
      n_fail++; $display("FAIL basic_aw_w_ready: got %b expected 11", {awready1, wready1});
    end
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    n_tests++;
    if (bvalid1 !== 1'b0) begin
      n_fail++; $display("FAIL basic_b_early: bvalid=%0b in commit cycle, expected 0", bvalid1);
    end
    tick();
    n_tests++;
    if (bvalid1 !== 1'b1) begin
      n_fail++; $display("FAIL basic_b_timing: bvalid=%0b after commit, expected 1", bvalid1);
    end
    tick();
    araddr = 16'h0010; arvalid1 = 1'b1;
    rq1.push_back('{d: 32'hDEADBEEF, r: 2'b00});
    #1;
    n_tests++;
    if (arready1 !== 1'b1) begin
      n_fail++; $display("FAIL basic_arready: got %0b expected 1", arready1);
    end
    tick();
    arvalid1 = 1'b0;
    n_tests++;
    if (rvalid1 !== 1'b1) begin
      n_fail++; $display("FAIL basic_r_latency: rvalid=%0b one cycle after AR, expected 1", rvalid1);
    end
    tick();
    n_tests++;
    if ({rvalid1, arready1} !== 2'b01) begin
      n_fail++; $display("FAIL basic_ar_reopen: rvalid,arready=%b expected 01", {rvalid1, arready1});
    end
    drain();
  endtask

  task automatic test_ooo_strobe();
    wdata = 32'h11223344; wstrb = 4'h5; wvalid = 1'b1;
    bq.push_back(2'b00);
    model_wr(16'h0010, 32'h11223344, 4'h5);
    #1;
    n_tests++;
    if (wready1 !== 1'b1) begin
      n_fail++; $display("FAIL ooo_wready: got %0b expected 1", wready1);
    end
    tick();
    wvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_tests++;
      if ({awready1, wready1, bvalid1} !== 3'b100) begin
        n_fail++;
        $display("FAIL ooo_w_held[%0d]: awready,wready,bvalid=%b expected 100", i, {awready1, wready1, bvalid1});
      end
      tick();
    end
    awaddr = 16'h0010; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    drain();
    drive_read1(16'h0010, 32'hDE22BE44, 2'b00);
    drain();
  endtask

  task automatic test_out_of_range();
    drive_write(16'h0000, 32'h01020304, 4'hF, 2'b00);
    drive_write(16'h1000, 32'hCAFEF00D, 4'hF, 2'b11);
    drain();
    drive_read1(16'h1000, 32'h0, 2'b11);
    drive_read1(16'h0000, 32'h01020304, 2'b00);
    drain();
  endtask

  task automatic test_backpressure();
    bit ok;
    int k;
    bready = 1'b0;
    drive_write(16'h1004, 32'hAAAA0001, 4'hF, 2'b11);
    drive_write(16'h0024, 32'hBBBB0002, 4'hF, 2'b00);
    awaddr = 16'h0028; wdata = 32'hCCCC0003; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    bq.push_back(2'b00);
    model_wr(16'h0028, 32'hCCCC0003, 4'hF);
    for (int i = 0; i < 5; i++) begin
      #1;
      n_tests++;
      if ({awready1, wready1, bvalid1, bresp1} !== 5'b00111) begin
        n_fail++;
        $display("FAIL bp_stall[%0d]: awready,wready,bvalid,bresp=%b expected 00111", i,
                 {awready1, wready1, bvalid1, bresp1});
      end
      tick();
    end
    bready = 1'b1;
    ok = 0; k = 0;
    while (!ok && k < 10) begin
      #1;
      if (awready1 && wready1) ok = 1;
      tick();
      k++;
    end
    awvalid = 1'b0; wvalid = 1'b0;
    if (!ok) begin
      n_tests++; n_fail++;
      $display("FAIL bp_third_accept: third pair never accepted, expected accepted");
    end
    drain();
    drive_read1(16'h0024, 32'hBBBB0002, 2'b00);
    drive_read1(16'h0028, 32'hCCCC0003, 2'b00);
    drain();
  endtask

  task automatic test_back_to_back();
    bready = 1'b1;
    awvalid = 1'b1; wvalid = 1'b1; wstrb = 4'hF;
    for (int i = 0; i < 4; i++) begin
      awaddr = 16'h0040 + 16'(4*i);
      wdata  = 32'h50000000 + 32'(i);
      bq.push_back(2'b00);
      model_wr(awaddr, wdata, 4'hF);
      #1;
      n_tests++;
      if ({awready1, wready1} !== 2'b11) begin
        n_fail++; $display("FAIL b2b_ready[%0d]: got %b expected 11", i, {awready1, wready1});
      end
      tick();
    end
    awvalid = 1'b0; wvalid = 1'b0;
    drain();
    for (int i = 0; i < 4; i++) drive_read1(16'h0040 + 16'(4*i), model[16 + i], 2'b00);
    drain();
  endtask

  task automatic test_latency4();
    rready4 = 1'b0;
    araddr = 16'h0044; arvalid4 = 1'b1;
    rq4.push_back('{d: 32'h50000001, r: 2'b00});
    #1;
    n_tests++;
    if (arready4 !== 1'b1) begin
      n_fail++; $display("FAIL lat4_arready: got %0b expected 1", arready4);
    end
    tick();
    arvalid4 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      n_tests++;
      if (rvalid4 !== (k == 3)) begin
        n_fail++; $display("FAIL lat4_rvalid[%0d]: got %0b expected %0b", k, rvalid4, (k == 3));
      end
      if (k < 3) tick();
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++;
      if (rvalid4 !== 1'b1 || rdata4 !== 32'h50000001 || arready4 !== 1'b0) begin
        n_fail++;
        $display("FAIL lat4_stall[%0d]: rvalid=%0b rdata=%h arready=%0b expected 1/50000001/0",
                 i, rvalid4, rdata4, arready4);
      end
    end
    rready4 = 1'b1;
    tick();
    n_tests++;
    if ({rvalid4, arready4} !== 2'b01) begin
      n_fail++; $display("FAIL lat4_reopen: rvalid,arready=%b expected 01", {rvalid4, arready4});
    end
    drain();
  endtask

  task automatic test_reset_mid();
    bready = 1'b1; rready4 = 1'b1; rready1 = 1'b1;
    araddr = 16'h0048; arvalid4 = 1'b1;
    rq4.push_back('{d: 32'h50000002, r: 2'b00});
    tick();
    arvalid4 = 1'b0;
    awaddr = 16'h0048; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    rst = 1'b1;
    rq4.delete();
    for (int i = 0; i < 2; i++) begin
      tick();
      n_tests++;
      if ({awready1, wready1, bvalid1, arready1, rvalid1, awready4, wready4, bvalid4, arready4, rvalid4} !== '0) begin
        n_fail++;
        $display("FAIL rst_mid_outputs[%0d]: dut1=%b dut4=%b expected all 0", i,
                 {awready1, wready1, bvalid1, arready1, rvalid1}, {awready4, wready4, bvalid4, arready4, rvalid4});
      end
    end
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_tests++;
      if ({bvalid1, rvalid1, rvalid4} !== 3'b000) begin
        n_fail++; $display("FAIL rst_no_stale[%0d]: bvalid,rvalid1,rvalid4=%b expected 000", i, {bvalid1, rvalid1, rvalid4});
      end
    end
    // lone W must wait: the pre-reset AW was dropped
    wdata = 32'hFFFFFFFF; wstrb = 4'hF; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++;
      if (bvalid1 !== 1'b0) begin
        n_fail++; $display("FAIL rst_aw_cleared[%0d]: bvalid=%0b expected 0", i, bvalid1);
      end
    end
    awaddr = 16'h004C; awvalid = 1'b1;
    bq.push_back(2'b00);
    model_wr(16'h004C, 32'hFFFFFFFF, 4'hF);
    tick();
    awvalid = 1'b0;
    drain();
    drive_read1(16'h0048, 32'h50000002, 2'b00);
    drive_read1(16'h004C, 32'hFFFFFFFF, 2'b00);
    drain();
  endtask

  initial begin
    rst = 1'b1;
    awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0;
    arvalid1 = 1'b0; rready1 = 1'b0; arvalid4 = 1'b0; rready4 = 1'b0;
    test_reset();
    test_basic();
    test_ooo_strobe();
    test_out_of_range();
    test_backpressure();
    test_back_to_back();
    test_latency4();
    test_reset_mid();
    repeat (2) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
